// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_in over a
// programmable window of ACLK cycles and publishes the result for a register slave.
module ro_freq_counter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GATE_W      = 24,
  parameter int unsigned SYNC_STAGES = 2   // must be at least 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ro_in,
  input  logic              enable,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        meas_id
);

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                rise_prev_q;
  logic                rise;
  logic                load;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [CNT_W-1:0]    edge_cnt_q;
  logic                sat_q;
  logic [CNT_W-1:0]    count_q;
  logic                ovf_q;
  logic [7:0]          id_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync_q      <= '0;
      rise_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ro_in};
      rise_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~rise_prev_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start && enable && (gate_len != '0)) state_d = StGate;
      StGate: begin
        if (!enable)                         state_d = StIdle;
        else if (gate_cnt_q == GATE_W'(1))   state_d = StDone;
      end
      // A zero gate_len cannot re-arm: it would open a 2^GATE_W-cycle window.
      StDone: state_d = (enable && continuous && (gate_len != '0)) ? StGate : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign load = (state_d == StGate) && (state_q != StGate);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      id_q       <= 8'd0;
    end else begin
      if (load) begin
        gate_cnt_q <= gate_len;
        edge_cnt_q <= '0;
        sat_q      <= 1'b0;
      end else if (state_q == StGate) begin
        gate_cnt_q <= gate_cnt_q - GATE_W'(1);
        if (rise) begin
          if (&edge_cnt_q) sat_q      <= 1'b1;
          else             edge_cnt_q <= edge_cnt_q + CNT_W'(1);
        end
      end
      if (count_valid) begin
        count_q <= edge_cnt_q;
        ovf_q   <= sat_q;
        id_q    <= id_q + 8'd1;
      end
    end
  end

  // The new result is presented during the pulse itself and held in count_q afterwards.
  always_comb begin
    busy        = (state_q == StGate) || (state_q == StDone);
    count_valid = (state_q == StDone) && enable;
    count_out   = count_q;
    overflow    = ovf_q;
    meas_id     = id_q;
    if (count_valid) begin
      count_out = edge_cnt_q;
      overflow  = sat_q;
      meas_id   = id_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a cycle-level behavioural model checked every cycle against a
// 32-bit and a 4-bit counter instance, plus directed scenarios with literal expectations.
module tb_ro_freq_counter;
  localparam int S = 2;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ro_in = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [23:0] gate_len = 24'd0;

  logic [31:0] count_a;
  logic        valid_a, busy_a, ovf_a;
  logic [7:0]  id_a;
  logic [3:0]  count_b;
  logic        valid_b, busy_b, ovf_b;
  logic [7:0]  id_b;

  ro_freq_counter #(.CNT_W(32), .GATE_W(24), .SYNC_STAGES(S)) dut_a (
    .ACLK(ACLK), .ARESET(ARESET), .ro_in(ro_in), .enable(enable), .start(start),
    .continuous(continuous), .gate_len(gate_len), .count_out(count_a),
    .count_valid(valid_a), .busy(busy_a), .overflow(ovf_a), .meas_id(id_a)
  );

  ro_freq_counter #(.CNT_W(4), .GATE_W(24), .SYNC_STAGES(S)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET), .ro_in(ro_in), .enable(enable), .start(start),
    .continuous(continuous), .gate_len(gate_len), .count_out(count_b),
    .count_valid(valid_b), .busy(busy_b), .overflow(ovf_b), .meas_id(id_b)
  );

  always #5 ACLK = ~ACLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Square wave on ro_in with a period of ro_period ACLK cycles (0 holds it low).
  int ro_period = 0;
  int ph = 0;
  always @(posedge ACLK) begin
    #2;
    if (ro_period > 1) begin
      ph    = (ph + 1) % ro_period;
      ro_in = (ph < ro_period / 2);
    end else begin
      ro_in = 1'b0;
    end
  end

  // Behavioural model: a measurement is a window of gate_len cycles in which rises of the
  // delayed ro_in sample stream are counted without bound, then clipped per counter width.
  bit          m_ok = 0;
  bit          m_win = 0, m_done = 0;
  int          m_left = 0;
  longint      m_edges = 0;
  longint      m_cnt_a = 0, m_cnt_b = 0;
  bit          m_ovf_a = 0, m_ovf_b = 0;
  int          m_id = 0;
  logic [S:0]  hist = '0;

  function automatic longint clip(input longint e, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (e > mx) ? mx : e;
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      m_ok = 1; m_win = 0; m_done = 0; m_edges = 0; m_left = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_ovf_a = 0; m_ovf_b = 0; m_id = 0; hist = '0;
    end else begin
      if (m_win) begin
        if (hist[S-1] && !hist[S]) m_edges++;
        m_left--;
        if (!enable) m_win = 0;
        else if (m_left == 0) begin m_win = 0; m_done = 1; end
      end else if (m_done) begin
        m_done = 0;
        if (enable) begin
          m_cnt_a = clip(m_edges, 32); m_ovf_a = (m_edges > clip(m_edges, 32));
          m_cnt_b = clip(m_edges, 4);  m_ovf_b = (m_edges > clip(m_edges, 4));
          m_id = (m_id + 1) % 256;
          if (continuous && gate_len != 0) begin
            m_win = 1; m_left = int'(gate_len); m_edges = 0;
          end
        end
      end else if (start && enable && gate_len != 0) begin
        m_win = 1; m_left = int'(gate_len); m_edges = 0;
      end
      hist = {hist[S-1:0], ro_in};
    end
  end

  // Compare process plus capture of the last result for the directed checks.
  int cyc = 0, nvalid = 0, cur_run = 0, last_run = 0, last_vcyc = 0, prev_vcyc = 0;
  logic [31:0] last_cnt_a;
  logic [3:0]  last_cnt_b;
  logic        last_ovf_a, last_ovf_b;
  logic [7:0]  last_id;

  always @(negedge ACLK) begin
    bit ev;
    cyc++;
    if (m_ok) begin
      ev = m_done && enable;
      check("busy_a", busy_a, m_win || m_done);
      check("valid_a", valid_a, ev);
      check("count_a", count_a, ev ? clip(m_edges, 32) : m_cnt_a);
      check("ovf_a", ovf_a, ev ? (m_edges > clip(m_edges, 32)) : m_ovf_a);
      check("id_a", id_a, ev ? (m_id + 1) % 256 : m_id);
      check("valid_b", valid_b, ev);
      check("count_b", count_b, ev ? clip(m_edges, 4) : m_cnt_b);
      check("ovf_b", ovf_b, ev ? (m_edges > clip(m_edges, 4)) : m_ovf_b);
      check("id_b", id_b, ev ? (m_id + 1) % 256 : m_id);
    end
    if (valid_a) begin
      nvalid++;
      last_cnt_a = count_a; last_ovf_a = ovf_a; last_id = id_a;
      last_cnt_b = count_b; last_ovf_b = ovf_b;
      prev_vcyc = last_vcyc; last_vcyc = cyc;
    end
    if (busy_a) cur_run++;
    else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge ACLK); #2; end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int bound);
    int n = 0;
    while (nvalid < target && n < bound) begin tick(1); n++; end
    if (nvalid < target) check("timeout_valid", nvalid, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion",
             vectors);
    $fatal(1);
  end

  initial begin
    int n0;
    tick(3);
    ARESET = 1'b0;
    check("rst_count", count_a, 0); check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);   check("rst_ovf", ovf_a, 0); check("rst_id", id_a, 0);

    // Basic count: period 8 over 80 cycles.
    enable = 1'b1; ro_period = 8; gate_len = 24'd80; tick(20);
    n0 = nvalid; pulse_start(); wait_valid(n0 + 1, 200); tick(3);
    check("basic_cnt", last_cnt_a, 10); check("basic_ovf", last_ovf_a, 0);
    check("basic_id", last_id, 1);      check("basic_busy_len", last_run, 81);

    // Saturation on the 4-bit instance, then a non-saturating run.
    ro_period = 4; tick(20);
    n0 = nvalid; pulse_start(); wait_valid(n0 + 1, 200);
    check("sat_cnt_b", last_cnt_b, 15); check("sat_ovf_b", last_ovf_b, 1);
    check("sat_cnt_a", last_cnt_a, 20); check("sat_ovf_a", last_ovf_a, 0);
    ro_period = 8; gate_len = 24'd40; tick(20);
    n0 = nvalid; pulse_start(); wait_valid(n0 + 1, 200);
    check("unsat_cnt_b", last_cnt_b, 5); check("unsat_ovf_b", last_ovf_b, 0);
    check("unsat_id", last_id, 3);

    // Continuous mode: results every 17 cycles; clearing continuous lets one more finish.
    ro_period = 4; gate_len = 24'd16; continuous = 1'b1; tick(10);
    n0 = nvalid; pulse_start();
    wait_valid(n0 + 1, 100); check("cont1_cnt", last_cnt_a, 4); check("cont1_id", last_id, 4);
    wait_valid(n0 + 2, 100); check("cont2_id", last_id, 5);
    check("cont2_space", last_vcyc - prev_vcyc, 17);
    wait_valid(n0 + 3, 100); check("cont3_id", last_id, 6);
    check("cont3_space", last_vcyc - prev_vcyc, 17);
    continuous = 1'b0;
    wait_valid(n0 + 4, 100); check("cont4_id", last_id, 7);
    check("cont4_space", last_vcyc - prev_vcyc, 17); check("cont4_cnt", last_cnt_a, 4);
    tick(40); check("cont_stop_n", nvalid, n0 + 4); check("cont_stop_busy", busy_a, 0);

    // Abort with enable=0 mid-window.
    gate_len = 24'd80; tick(10);
    n0 = nvalid; pulse_start(); tick(29); enable = 1'b0; tick(1);
    check("abort_busy", busy_a, 0);
    enable = 1'b1; tick(100);
    check("abort_n", nvalid, n0); check("abort_cnt", count_a, 4); check("abort_id", id_a, 7);

    // A second start while busy is ignored.
    n0 = nvalid; pulse_start(); tick(10); pulse_start();
    wait_valid(n0 + 1, 200); tick(100);
    check("busy_start_n", nvalid, n0 + 1); check("busy_start_len", last_run, 81);
    check("busy_start_id", last_id, 8);    check("busy_start_cnt", last_cnt_a, 20);

    // Reset mid-window, then a start with gate_len=0.
    pulse_start(); tick(19); ARESET = 1'b1; tick(1); ARESET = 1'b0;
    check("rst_mid_cnt", count_a, 0); check("rst_mid_busy", busy_a, 0);
    check("rst_mid_id", id_a, 0);     check("rst_mid_valid", valid_a, 0);
    gate_len = 24'd0; n0 = nvalid; pulse_start(); tick(5);
    check("zero_gate_busy", busy_a, 0); check("zero_gate_n", nvalid, n0);

    // meas_id wrap after 256 back-to-back results.
    gate_len = 24'd2; continuous = 1'b1; n0 = nvalid; pulse_start();
    wait_valid(n0 + 256, 256 * 3 + 50);
    check("wrap_id", last_id, 0); check("wrap_space", last_vcyc - prev_vcyc, 3);
    continuous = 1'b0; tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
